ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/fpga_cfg_pkg.sv | 21 ++
 rtl/ccff_chain_loader.sv | 147 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration-fabric definitions: loader FSM states and default
// geometry of the ccff chain and its bitstream feed.
package fpga_cfg_pkg;

  localparam int CCFF_CHAIN_LEN = 30;   // 10 muxes x 3 sram bits
  localparam int CFG_WORD_W     = 8;
  localparam int CFG_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccff_chain_loader.sv
// Serialises a word-wide bitstream, MSB first, into a configuration flip-flop
// chain. Words are fetched with a valid/ready handshake; each word is then
// shifted out one bit per cycle with shift_en driving the chain's clock gate.
// A stalled feed aborts with err after TIMEOUT cycles.
module ccff_chain_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
  parameter int WORD_W    = CFG_WORD_W,
  parameter int TIMEOUT   = CFG_TIMEOUT
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TOT_W   = cnt_width(CHAIN_LEN + 1);
  localparam int BIT_W   = cnt_width(WORD_W);
  localparam int STALL_W = cnt_width(TIMEOUT + 1);

  localparam logic [TOT_W-1:0]   LAST_CHAIN_BIT = TOT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0]   LAST_WORD_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [STALL_W-1:0] LAST_STALL     = STALL_W'(TIMEOUT - 1);

  ccff_state_e r_state;
  ccff_state_e w_state_nxt;

  logic [WORD_W-1:0]  r_word;
  logic [TOT_W-1:0]   r_total;
  logic [BIT_W-1:0]   r_bit;
  logic [STALL_W-1:0] r_stall;
  logic               r_err;

  logic w_clear;
  logic w_load;
  logic w_shift;
  logic w_stall_inc;
  logic w_timeout;

  // State register.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath strobes and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_stall_inc = 1'b0;
    w_timeout   = 1'b0;

    cfg_ready = (r_state == ST_FETCH);
    shift_en  = (r_state == ST_SHIFT);
    ccff_head = (r_state == ST_SHIFT) && r_word[WORD_W-1];
    busy      = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
    done      = (r_state == ST_DONE);
    err       = r_err;

    if (abort) begin
      // Abort suppresses every strobe, so a concurrent handshake is dropped.
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (cfg_valid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_stall_inc = 1'b1;
            if (r_stall == LAST_STALL) begin
              w_timeout   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_SHIFT: begin
          w_shift = 1'b1;
          // Chain completion wins over end-of-word; leftover word bits are dropped.
          if (r_total == LAST_CHAIN_BIT) begin
            w_state_nxt = ST_DONE;
          end else if (r_bit == LAST_WORD_BIT) begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Word shift register, bit/total/stall counters and the err pulse flop.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_word  <= '0;
      r_total <= '0;
      r_bit   <= '0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_clear) begin
        r_total <= '0;
        r_stall <= '0;
      end
      if (w_load) begin
        r_word  <= cfg_data;
        r_bit   <= '0;
        r_stall <= '0;
      end else if (w_stall_inc) begin
        r_stall <= r_stall + STALL_W'(1);
      end
      if (w_shift) begin
        r_word  <= r_word << 1;
        r_total <= r_total + TOT_W'(1);
        if (r_bit != LAST_WORD_BIT) begin
          r_bit <= r_bit + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: stimulus pushes expected chain
// events (shift bits with cycle stamps, done, err); a negedge monitor pops
// and compares them. A 30-flop enable-gated chain model provides the sram
// readback of the 10 mux stages.
module tb_ccff_chain_loader;

  logic       prog_clk     = 1'b0;
  logic       prog_reset_n = 1'b0;
  logic       start        = 1'b0;
  logic       abort        = 1'b0;
  logic       cfg_valid    = 1'b0;
  logic [7:0] cfg_data     = '0;
  logic       cfg_ready, ccff_head, shift_en, busy, done, err;

  ccff_chain_loader #(
    .CHAIN_LEN(30),
    .WORD_W   (8),
    .TIMEOUT  (255)
  ) dut (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .start       (start),
    .abort       (abort),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .ccff_head   (ccff_head),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 prog_clk = ~prog_clk;

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain behind the clock gate: advances only on edges with shift_en=1.
  logic [29:0] chain = '0;
  always @(posedge prog_clk) if (shift_en) chain <= {chain[28:0], ccff_head};

  typedef struct {
    int   kind;   // 0 shift bit, 1 done, 2 err
    logic b;
    int   cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] pat[4];
  int         stall[4];
  logic [2:0] exp_sram[10];
  int         t0;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: every chain event must match the head of the scoreboard.
  always @(negedge prog_clk) begin : mon
    exp_t e;
    int   act;
    if (cfg_ready && shift_en) begin
      n_total++;
      $display("FAIL ready_shift_excl: cfg_ready=1 shift_en=1 at cycle %0d", cyc);
    end
    if (shift_en || done || err) begin
      act = shift_en ? 0 : (done ? 1 : 2);
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", act, cyc);
      end else begin
        e = sb_q.pop_front();
        if (act == e.kind && cyc == e.cyc && (act != 0 || ccff_head == e.b))
          n_pass++;
        else
          $display("FAIL event: got kind %0d bit %0b cycle %0d, expected kind %0d bit %0b cycle %0d",
                   act, ccff_head, cyc, e.kind, e.b, e.cyc);
      end
    end
  end

  // Expected event timeline of a load starting at t0, truncated after maxc.
  task automatic push_load(input int maxc);
    int   c;
    int   bits;
    exp_t e;
    c    = t0 + 1;
    bits = 0;
    for (int w = 0; w < 4; w++) begin
      c += stall[w];
      for (int i = 0; i < 8; i++) begin
        if (bits < 30) begin
          c++;
          e.kind = 0; e.b = pat[w][7-i]; e.cyc = c;
          if (c <= maxc) sb_q.push_back(e);
          bits++;
        end
      end
      if (bits == 30) break;
      c++;
    end
    c++;
    e.kind = 1; e.b = 1'b0; e.cyc = c;
    if (c <= maxc) sb_q.push_back(e);
  endtask

  task automatic do_start();
    @(posedge prog_clk); #1;
    start = 1'b1;
    t0    = cyc;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int nw);
    int k;
    for (int w = 0; w < nw; w++) begin
      k = 0;
      @(negedge prog_clk);
      while (!cfg_ready && k < 600) begin
        @(negedge prog_clk);
        k++;
      end
      if (!cfg_ready) begin
        n_total++;
        $display("FAIL feed_ready: word %0d got cfg_ready=0 expected 1 within 600 cycles", w);
        return;
      end
      repeat (stall[w]) @(negedge prog_clk);
      cfg_valid = 1'b1;
      cfg_data  = pat[w];
      @(posedge prog_clk); #1;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      @(negedge prog_clk);
      k++;
    end
    repeat (4) @(negedge prog_clk);
    chk({name, "_pending"}, sb_q.size(), 0);
  endtask

  task automatic check_chain(input logic inv);
    logic [2:0] e3;
    for (int k = 0; k < 10; k++) begin
      e3 = inv ? ~exp_sram[k] : exp_sram[k];
      chk($sformatf("stage%0d_sram", k), int'(chain[3*k +: 3]), int'(e3));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 0);
    chk({tag, "_ccff_head"}, int'(ccff_head), 0);
    chk({tag, "_shift_en"},  int'(shift_en),  0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_done"},      int'(done),      0);
    chk({tag, "_err"},       int'(err),       0);
  endtask

  task automatic set_pat(input logic inv);
    pat[0] = inv ? 8'h5A : 8'hA5;
    pat[1] = inv ? 8'hC3 : 8'h3C;
    pat[2] = inv ? 8'h0F : 8'hF0;
    pat[3] = inv ? 8'h69 : 8'h96;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream A5 3C F0 96[7:2] lands as chain[29:0]; stage k sram = chain[3k+2:3k].
    exp_sram = '{3'b101, 3'b100, 3'b000, 3'b110, 3'b011,
                 3'b110, 3'b011, 3'b010, 3'b001, 3'b101};
    stall = '{0, 0, 0, 0};
    set_pat(1'b0);

    #2;
    check_all_zero("reset");
    #20 prog_reset_n = 1'b1;

    // Always-valid stream: bursts 8/8/8/6, done at t0+35.
    do_start();
    push_load(t0 + 1000);
    feed(4);
    drain("load_basic");
    check_chain(1'b0);

    // Ten-cycle stall before the second word; inverted data.
    set_pat(1'b1);
    stall = '{0, 10, 0, 0};
    do_start();
    push_load(t0 + 1000);
    feed(4);
    drain("load_stall");
    check_chain(1'b1);

    // No data at all: err pulse once the stall count reaches 255.
    begin
      exp_t e;
      do_start();
      e.kind = 2; e.b = 1'b0; e.cyc = t0 + 256;
      sb_q.push_back(e);
      while (cyc < t0 + 255) @(negedge prog_clk);
      chk("timeout_busy_before", int'(busy), 1);
      @(negedge prog_clk);
      chk("timeout_busy_after", int'(busy), 0);
      drain("timeout");
    end

    // Abort during the third word's shifting, then a clean reload.
    set_pat(1'b0);
    stall = '{0, 0, 0, 0};
    do_start();
    push_load(t0 + 22);
    feed(3);
    while (cyc < t0 + 22) begin
      @(posedge prog_clk); #1;
    end
    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    @(negedge prog_clk);
    chk("abort_shift_en", int'(shift_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cfg_ready", int'(cfg_ready), 0);
    drain("abort");
    do_start();
    push_load(t0 + 1000);
    feed(4);
    drain("after_abort");
    check_chain(1'b0);

    // Asynchronous reset in mid-shift, then a clean reload.
    do_start();
    push_load(t0 + 4);
    feed(1);
    while (cyc < t0 + 5) begin
      @(posedge prog_clk); #1;
    end
    #2 prog_reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge prog_clk);
    @(posedge prog_clk); #3;
    prog_reset_n = 1'b1;
    drain("midreset");
    set_pat(1'b1);
    do_start();
    push_load(t0 + 1000);
    feed(4);
    drain("after_reset");
    check_chain(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
